// File: rtl/msdap_out_serializer_if.sv
// ---------------------------------------------------------------------------
// msdap_out_serializer_if
//   Bundle between the MSDAP filter datapath and the stereo output serializer.
//   The serializer is the slave; the datapath (or a bench) is the master.
//
//   Signals
//     Frame       frame-start pulse, one Sclk cycle wide
//     load_valid  datapath presents a left/right result pair
//     load_ready  serializer holding register is empty
//     dataL_in    left-channel result word  (DATA_W bits)
//     dataR_in    right-channel result word (DATA_W bits)
//     err_clr     synchronous clear of the sticky error flags
//     OutReady    serial bits on OutputL/OutputR are valid
//     OutputL     left serial bit, MSB first
//     OutputR     right serial bit, MSB first
//     underrun    sticky: Frame with nothing to send
//     overrun     sticky: Frame while a word was still shifting
//
//   DATA_W must match the DATA_W of the attached serializer.
// ---------------------------------------------------------------------------
interface msdap_out_serializer_if #(
    parameter int DATA_W = 40
);
    logic              Frame;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] dataL_in;
    logic [DATA_W-1:0] dataR_in;
    logic              err_clr;
    logic              OutReady;
    logic              OutputL;
    logic              OutputR;
    logic              underrun;
    logic              overrun;

    modport master (
        output Frame, load_valid, dataL_in, dataR_in, err_clr,
        input  load_ready, OutReady, OutputL, OutputR, underrun, overrun
    );

    modport slave (
        input  Frame, load_valid, dataL_in, dataR_in, err_clr,
        output load_ready, OutReady, OutputL, OutputR, underrun, overrun
    );
endinterface

// File: rtl/msdap_out_serializer.sv
// ---------------------------------------------------------------------------
// msdap_out_serializer
//   Frame-synchronised stereo output serializer for the MSDAP. Accepts one
//   left/right result pair into a single-entry holding register and, on each
//   Frame pulse, shifts the pair out MSB-first on OutputL/OutputR while
//   OutReady frames the DATA_W-bit word. The holding register may be
//   refilled while a word is shifting (double buffer).
//
//   Ports
//     Sclk   serial/system clock, rising edge
//     Reset  asynchronous, active-high reset
//     bus    msdap_out_serializer_if.slave (Frame, load handshake, data,
//            err_clr in; load_ready, OutReady, OutputL/R, underrun,
//            overrun out)
//
//   Parameters
//     DATA_W  word width and bits shifted per frame
//     CNT_W   bit-counter width, 2**CNT_W >= DATA_W
//
//   Build option
//     MSDAP_OUT_ZERO_FILL_EN  when defined, a Frame with an empty holding
//                             register still sends an all-zero word (and
//                             sets underrun); otherwise nothing is sent.
// ---------------------------------------------------------------------------
module msdap_out_serializer #(
    parameter int DATA_W = 40,
    parameter int CNT_W  = 6
) (
    input  logic                  Sclk,
    input  logic                  Reset,
    msdap_out_serializer_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic              hold_valid, hold_valid_nxt;
    logic [DATA_W-1:0] holdL, holdL_nxt;
    logic [DATA_W-1:0] holdR, holdR_nxt;
    logic [DATA_W-1:0] shiftL, shiftL_nxt;
    logic [DATA_W-1:0] shiftR, shiftR_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              underrun, underrun_nxt;
    logic              overrun, overrun_nxt;
    logic              underrun_set, overrun_set;
    logic              load_fire;

    // A transfer only happens with hold_valid=1, when load_ready is 0, so a
    // load and a transfer can never land on the same edge.
    assign load_fire = bus.load_valid & ~hold_valid;

    always_comb begin
        state_nxt      = state;
        hold_valid_nxt = hold_valid;
        holdL_nxt      = holdL;
        holdR_nxt      = holdR;
        shiftL_nxt     = shiftL;
        shiftR_nxt     = shiftR;
        cnt_nxt        = cnt;
        underrun_set   = 1'b0;
        overrun_set    = 1'b0;

        if (load_fire) begin
            hold_valid_nxt = 1'b1;
            holdL_nxt      = bus.dataL_in;
            holdR_nxt      = bus.dataR_in;
        end

        unique case (state)
            IDLE: begin
                if (bus.Frame) begin
                    if (hold_valid) begin
                        state_nxt      = SHIFT;
                        shiftL_nxt     = holdL;
                        shiftR_nxt     = holdR;
                        hold_valid_nxt = 1'b0;
                        cnt_nxt        = CNT_W'(DATA_W - 1);
                    end else begin
                        underrun_set = 1'b1;
`ifdef MSDAP_OUT_ZERO_FILL_EN
                        state_nxt  = SHIFT;
                        shiftL_nxt = '0;
                        shiftR_nxt = '0;
                        cnt_nxt    = CNT_W'(DATA_W - 1);
`endif
                    end
                end
            end
            SHIFT: begin
                // A Frame here is only flagged; the word in flight is untouched.
                overrun_set = bus.Frame;
                if (cnt == '0) begin
                    // Clearing here keeps the serial lines at 0 while idle.
                    state_nxt  = IDLE;
                    shiftL_nxt = '0;
                    shiftR_nxt = '0;
                end else begin
                    shiftL_nxt = {shiftL[DATA_W-2:0], 1'b0};
                    shiftR_nxt = {shiftR[DATA_W-2:0], 1'b0};
                    cnt_nxt    = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Set wins over a coincident clear.
        underrun_nxt = underrun_set | (underrun & ~bus.err_clr);
        overrun_nxt  = overrun_set  | (overrun  & ~bus.err_clr);
    end

    always_ff @(posedge Sclk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            holdL      <= '0;
            holdR      <= '0;
            shiftL     <= '0;
            shiftR     <= '0;
            cnt        <= '0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_valid <= hold_valid_nxt;
            holdL      <= holdL_nxt;
            holdR      <= holdR_nxt;
            shiftL     <= shiftL_nxt;
            shiftR     <= shiftR_nxt;
            cnt        <= cnt_nxt;
            underrun   <= underrun_nxt;
            overrun    <= overrun_nxt;
        end
    end

    // Every output comes straight from a flop.
    assign bus.load_ready = ~hold_valid;
    assign bus.OutReady   = (state == SHIFT);
    assign bus.OutputL    = shiftL[DATA_W-1];
    assign bus.OutputR    = shiftR[DATA_W-1];
    assign bus.underrun   = underrun;
    assign bus.overrun    = overrun;

endmodule

// File: tb/tb_msdap_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_msdap_out_serializer
//   Self-checking bench for msdap_out_serializer. Words expected on the
//   serial lines are queued when their Frame is driven; a negedge monitor
//   reassembles each OutReady burst and compares it against the queue head.
//   Builds with or without MSDAP_OUT_ZERO_FILL_EN.
// ---------------------------------------------------------------------------
module tb_msdap_out_serializer;
    localparam int DATA_W = 40;
    localparam int CNT_W  = 6;

    typedef logic [DATA_W-1:0] word_t;
    typedef struct {
        word_t l;
        word_t r;
    } pair_t;

    logic Sclk = 1'b0;
    logic Reset;

    always #5 Sclk = ~Sclk;

    msdap_out_serializer_if #(.DATA_W(DATA_W)) bus ();

    msdap_out_serializer #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .Sclk (Sclk),
        .Reset(Reset),
        .bus  (bus)
    );

    int    tests = 0;
    int    fails = 0;
    pair_t sb[$];
    int    words_done = 0;
    int    mon_bits = 0;
    int    mon_gap = 0;
    int    last_gap = -1;
    word_t mon_l = '0;
    word_t mon_r = '0;
    pair_t mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serial monitor: samples away from the rising edge.
    always @(negedge Sclk) begin
        if (Reset) begin
            mon_bits = 0;
            mon_gap  = 0;
        end else if (bus.OutReady) begin
            if (mon_bits == 0) begin
                last_gap = mon_gap;
                mon_gap  = 0;
            end
            mon_l = {mon_l[DATA_W-2:0], bus.OutputL};
            mon_r = {mon_r[DATA_W-2:0], bus.OutputR};
            mon_bits++;
        end else begin
            check("idle_outL", 64'(bus.OutputL), 64'(0));
            check("idle_outR", 64'(bus.OutputR), 64'(0));
            if (mon_bits != 0) begin
                check("word_len", 64'(mon_bits), 64'(DATA_W));
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got L=%0h R=%0h, none expected", mon_l, mon_r);
                end else begin
                    mon_exp = sb.pop_front();
                    check("word_L", 64'(mon_l), 64'(mon_exp.l));
                    check("word_R", 64'(mon_r), 64'(mon_exp.r));
                end
                words_done++;
                mon_bits = 0;
            end
            mon_gap++;
        end
    end

    task automatic tick();
        @(posedge Sclk);
        #1;
    endtask

    task automatic load_word(input word_t l, input word_t r);
        int n;
        n = 0;
        while (!bus.load_ready && n < 200) begin
            tick();
            n++;
        end
        check("load_ready_wait", 64'(bus.load_ready), 64'(1));
        bus.load_valid = 1'b1;
        bus.dataL_in   = l;
        bus.dataR_in   = r;
        tick();
        bus.load_valid = 1'b0;
        check("load_ready_after_load", 64'(bus.load_ready), 64'(0));
    endtask

    task automatic pulse_frame(input bit push, input word_t l, input word_t r);
        pair_t p;
        if (push) begin
            p.l = l;
            p.r = r;
            sb.push_back(p);
        end
        bus.Frame = 1'b1;
        tick();
        bus.Frame = 1'b0;
    endtask

    task automatic wait_total(input int target);
        int budget;
        budget = 0;
        while (words_done < target && budget < 500) begin
            tick();
            budget++;
        end
        check("word_done_timeout", 64'(words_done >= target), 64'(1));
    endtask

    // Frame with an empty holding register.
    task automatic frame_empty();
`ifdef MSDAP_OUT_ZERO_FILL_EN
        pulse_frame(1'b1, '0, '0);
        check("zf_outready", 64'(bus.OutReady), 64'(1));
`else
        pulse_frame(1'b0, '0, '0);
`endif
    endtask

    task automatic drain_empty();
`ifdef MSDAP_OUT_ZERO_FILL_EN
        wait_total(words_done + 1);
`else
        for (int i = 0; i < 3; i++) begin
            check("underrun_no_tx", 64'(bus.OutReady), 64'(0));
            tick();
        end
`endif
    endtask

    task automatic clear_flags();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("clr_underrun", 64'(bus.underrun), 64'(0));
        check("clr_overrun", 64'(bus.overrun), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    pair_t vecs[4];
    int    base;
    word_t x_l, x_r, z_l, z_r;

    initial begin
        vecs[0] = '{l: 40'hFF_FFFF_FFFF, r: 40'h00_0000_0000};
        vecs[1] = '{l: 40'hA5_5A5A_A55A, r: 40'h5A_A5A5_5AA5};
        vecs[2] = '{l: 40'h00_0000_0001, r: 40'h80_0000_0000};
        vecs[3] = '{l: 40'h12_3456_789A, r: 40'hFE_DCBA_9876};

        Reset          = 1'b1;
        bus.Frame      = 1'b0;
        bus.load_valid = 1'b0;
        bus.dataL_in   = '0;
        bus.dataR_in   = '0;
        bus.err_clr    = 1'b0;
        repeat (2) @(posedge Sclk);
        #1;
        check("rst_load_ready", 64'(bus.load_ready), 64'(1));
        check("rst_outready", 64'(bus.OutReady), 64'(0));
        check("rst_outL", 64'(bus.OutputL), 64'(0));
        check("rst_outR", 64'(bus.OutputR), 64'(0));
        check("rst_underrun", 64'(bus.underrun), 64'(0));
        check("rst_overrun", 64'(bus.overrun), 64'(0));
        Reset = 1'b0;
        tick();

        // Basic word: first bit the cycle after the Frame edge.
        base = words_done;
        load_word(40'h80_0000_0001, 40'h00_0000_0003);
        check("pre_frame_outready", 64'(bus.OutReady), 64'(0));
        pulse_frame(1'b1, 40'h80_0000_0001, 40'h00_0000_0003);
        check("first_outready", 64'(bus.OutReady), 64'(1));
        check("first_bit_L", 64'(bus.OutputL), 64'(1));
        check("first_bit_R", 64'(bus.OutputR), 64'(0));
        wait_total(base + 1);
        check("t1_outready_low", 64'(bus.OutReady), 64'(0));
        check("t1_underrun", 64'(bus.underrun), 64'(0));
        check("t1_overrun", 64'(bus.overrun), 64'(0));

        // Table of words.
        for (int i = 0; i < 4; i++) begin
            base = words_done;
            load_word(vecs[i].l, vecs[i].r);
            pulse_frame(1'b1, vecs[i].l, vecs[i].r);
            wait_total(base + 1);
        end

        // Underrun, clear, and set-beats-clear.
        frame_empty();
        check("underrun_set", 64'(bus.underrun), 64'(1));
        drain_empty();
        clear_flags();
        bus.err_clr = 1'b1;
        frame_empty();
        bus.err_clr = 1'b0;
        check("underrun_set_wins", 64'(bus.underrun), 64'(1));
        drain_empty();
        clear_flags();

        // Double buffer and back-to-back with a single idle cycle.
        base = words_done;
        load_word(40'h0F_0F0F_0F0F, 40'hF0_F0F0_F0F0);
        pulse_frame(1'b1, 40'h0F_0F0F_0F0F, 40'hF0_F0F0_F0F0);
        repeat (5) tick();
        check("dbuf_ready", 64'(bus.load_ready), 64'(1));
        load_word(40'hFF_FFFF_FFFF, 40'h00_0000_0000);
        repeat (34) tick();
        check("b2b_idle_cycle", 64'(bus.OutReady), 64'(0));
        pulse_frame(1'b1, 40'hFF_FFFF_FFFF, 40'h00_0000_0000);
        check("b2b_start", 64'(bus.OutReady), 64'(1));
        wait_total(base + 2);
        check("b2b_gap", 64'(last_gap), 64'(1));
        check("b2b_overrun", 64'(bus.overrun), 64'(0));

        // Overrun: Frame mid-word, word completes, nothing extra is sent.
        base = words_done;
        load_word(40'hC3_3C3C_C33C, 40'h3C_C3C3_3CC3);
        pulse_frame(1'b1, 40'hC3_3C3C_C33C, 40'h3C_C3C3_3CC3);
        repeat (19) tick();
        pulse_frame(1'b0, '0, '0);
        check("overrun_set", 64'(bus.overrun), 64'(1));
        check("overrun_underrun", 64'(bus.underrun), 64'(0));
        wait_total(base + 1);
        repeat (60) tick();
        check("overrun_no_extra", 64'(words_done), 64'(base + 1));
        clear_flags();

        // Asynchronous reset mid-word.
        load_word(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
        pulse_frame(1'b1, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF);
        repeat (10) tick();
        check("pre_rst_outL", 64'(bus.OutputL), 64'(1));
        #1;
        Reset = 1'b1;
        sb.delete();
        #1;
        check("async_outready", 64'(bus.OutReady), 64'(0));
        check("async_outL", 64'(bus.OutputL), 64'(0));
        check("async_outR", 64'(bus.OutputR), 64'(0));
        check("async_load_ready", 64'(bus.load_ready), 64'(1));
        tick();
        Reset = 1'b0;
        tick();
        check("post_rst_load_ready", 64'(bus.load_ready), 64'(1));
        frame_empty();
        check("post_rst_underrun", 64'(bus.underrun), 64'(1));
        check("post_rst_overrun", 64'(bus.overrun), 64'(0));
        drain_empty();
        clear_flags();

        // Continuous load_valid: only edges with load_ready=1 capture.
        base = words_done;
        x_l = 40'h11_1111_1111;
        x_r = 40'h22_2222_2222;
        z_l = 40'h33_4455_6677;
        z_r = 40'h88_99AA_BBCC;
        bus.load_valid = 1'b1;
        bus.dataL_in   = x_l;
        bus.dataR_in   = x_r;
        tick();
        check("cont_ready_low", 64'(bus.load_ready), 64'(0));
        for (int i = 0; i < 4; i++) begin
            bus.dataL_in = word_t'({$urandom, $urandom});
            bus.dataR_in = word_t'({$urandom, $urandom});
            tick();
        end
        bus.dataL_in = z_l;
        bus.dataR_in = z_r;
        pulse_frame(1'b1, x_l, x_r);
        check("xfer_ready", 64'(bus.load_ready), 64'(1));
        tick();
        check("next_edge_load", 64'(bus.load_ready), 64'(0));
        bus.load_valid = 1'b0;
        wait_total(base + 1);
        pulse_frame(1'b1, z_l, z_r);
        wait_total(base + 2);

        repeat (3) tick();
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
